// File: rtl/fpu_rr_scheduler.sv
// Round-robin front end that shares one fixed-latency fpu between N_REQ requesters.
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module fpu_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int FPU_LATENCY = 8
) (
    input  logic                   clock100KHz,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [32*N_REQ-1:0]    req_op_a,
    input  logic [32*N_REQ-1:0]    req_op_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [3:0]             rsp_status,
    output logic                   rsp_flag,
    output logic [31:0]            fpu_op_a,
    output logic [31:0]            fpu_op_b,
    output logic                   fpu_start,
    input  logic [31:0]            fpu_data,
    input  logic [3:0]             fpu_status,
    input  logic                   fpu_flags,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [1:0]             fsm_state
);

    // Handshakes: a request transfers on the edge where req_valid[i] and req_ready[i]
    // are both high; a response transfers on the edge where rsp_valid[i] and rsp_ready[i]
    // are both high. Valids are held by their source until the matching ready is seen.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int CW = $clog2(FPU_LATENCY + 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      last;

    logic            win_found;
    logic [2:0]      win_idx;
    logic [2:0]      cand;
    logic            cand_valid;
    logic [31:0]     sel_op_a;
    logic [31:0]     sel_op_b;
    logic            rsp_hit;

    // Scan last+1, last+2, ... so the most recently served requester has lowest priority.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = 3'd0;
        cand       = 3'd0;
        cand_valid = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand       = 3'((int'(last) + k) % N_REQ);
            cand_valid = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (cand == 3'(i)) begin
                    cand_valid = req_valid[i];
                end
            end
            if (!win_found && cand_valid) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_op_a = 32'd0;
        sel_op_b = 32'd0;
        rsp_hit  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                sel_op_a = req_op_a[32*i +: 32];
                sel_op_b = req_op_b[32*i +: 32];
            end
            if (grant_id == 3'(i)) begin
                rsp_hit = rsp_ready[i];
            end
        end
    end

    // Only combinational output; suppressed under reset so nothing is accepted in that cycle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !reset) begin
            req_ready = N_REQ'(1) << win_idx;
        end
    end

    assign fsm_state = state;

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            last       <= 3'(N_REQ - 1);
            rsp_valid  <= '0;
            fpu_start  <= 1'b0;
            busy       <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_status <= 4'd0;
            rsp_flag   <= 1'b0;
            fpu_op_a   <= 32'd0;
            fpu_op_b   <= 32'd0;
            grant_id   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        fpu_op_a  <= sel_op_a;
                        fpu_op_b  <= sel_op_b;
                        grant_id  <= win_idx;
                        fpu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_start <= 1'b0;
                    count     <= CW'(FPU_LATENCY - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    // The fpu has no done flag: its outputs are valid once the count expires.
                    if (count == '0) begin
                        rsp_data   <= fpu_data;
                        rsp_status <= fpu_status;
                        rsp_flag   <= fpu_flags;
                        rsp_valid  <= N_REQ'(1) << grant_id;
                        state      <= RESP;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_hit) begin
                        rsp_valid <= '0;
                        last      <= grant_id;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Directed bench for fpu_rr_scheduler: vector table for arbitration order plus
// hand sequences for back-pressure, reset abort, operand hold and wrong-port ready.
module tb_fpu_rr_scheduler;
    localparam int N = 4;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = 4'd0;
    logic [127:0] req_op_a;
    logic [127:0] req_op_b;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready = 4'd0;
    logic [31:0]  rsp_data;
    logic [3:0]   rsp_status;
    logic         rsp_flag;
    logic [31:0]  fpu_op_a;
    logic [31:0]  fpu_op_b;
    logic         fpu_start;
    logic [31:0]  fpu_data;
    logic [3:0]   fpu_status;
    logic         fpu_flags;
    logic         busy;
    logic [2:0]   grant_id;
    logic [1:0]   fsm_state;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    localparam logic [127:0] OPS_A = {32'h40800000, 32'h3FC00000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] OPS_B = {32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40000000};
    logic [31:0] exp_a [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    fpu_rr_scheduler #(.N_REQ(N), .FPU_LATENCY(L)) dut (
        .clock100KHz(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_op_a(req_op_a),
        .req_op_b(req_op_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .rsp_flag(rsp_flag),
        .fpu_op_a(fpu_op_a),
        .fpu_op_b(fpu_op_b),
        .fpu_start(fpu_start),
        .fpu_data(fpu_data),
        .fpu_status(fpu_status),
        .fpu_flags(fpu_flags),
        .busy(busy),
        .grant_id(grant_id),
        .fsm_state(fsm_state)
    );

    // Single-precision add for positive normal operands, truncating.
    function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b;
        logic [7:0]  ea, eb, d;
        logic [23:0] ma, mb;
        logic [24:0] s;
        a = a_in;
        b = b_in;
        if (a_in[30:23] < b_in[30:23]) begin
            a = b_in;
            b = a_in;
        end
        ea = a[30:23];
        eb = b[30:23];
        d  = ea - eb;
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        mb = (d > 8'd23) ? 24'd0 : (mb >> d);
        s  = {1'b0, ma} + {1'b0, mb};
        if (s[24]) return {1'b0, ea + 8'd1, s[23:1]};
        return {1'b0, ea, s[22:0]};
    endfunction

    // Behavioural fpu: garbage until FPU_LATENCY cycles after fpu_start; flag = exponent lsb.
    logic [31:0] m_sum;
    logic [3:0]  m_cnt;
    assign m_sum = fadd(fpu_op_a, fpu_op_b);

    always @(posedge clk) begin
        if (reset) begin
            m_cnt      <= 4'd0;
            fpu_data   <= 32'hDEADBEEF;
            fpu_status <= 4'hF;
            fpu_flags  <= 1'b1;
        end else if (fpu_start) begin
            m_cnt      <= 4'(L - 1);
            fpu_data   <= 32'hDEADBEEF;
            fpu_status <= 4'hF;
            fpu_flags  <= 1'b1;
        end else if (m_cnt == 4'd1) begin
            m_cnt      <= 4'd0;
            fpu_data   <= m_sum;
            fpu_status <= 4'b0001;
            fpu_flags  <= m_sum[23];
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (rsp_valid == 4'd0 && k < 40) begin
            step();
            k++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 4'd0;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        reset     = 1'b0;
        req_valid = 4'd0;
        #1;
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_start", 32'(fpu_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outputs", {rsp_data ^ fpu_op_a ^ fpu_op_b, 32'd0} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        chk("rst_status_flag", {27'd0, rsp_status, rsp_flag}, 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] mask, input int g, input logic [31:0] d,
                          input logic f, output int t_acc);
        int k;
        logic [3:0] oh;
        oh        = 4'b0001 << g;
        rsp_ready = 4'd0;
        req_valid = mask;
        #1;
        k = 0;
        while (req_ready == 4'd0 && k < 20) begin
            step();
            #1;
            k++;
        end
        chk("grant_ready", 32'(req_ready), 32'(oh));
        t_acc = cyc_n;
        step();
        req_valid = 4'd0;
        chk("issue_start", 32'(fpu_start), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("issue_op_a", fpu_op_a, exp_a[g]);
        wait_rsp(k);
        chk("rsp_latency", 32'(k), 32'(L + 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_data", rsp_data, d);
        chk("rsp_status", 32'(rsp_status), 32'd1);
        chk("rsp_flag", 32'(rsp_flag), 32'(f));
        rsp_ready = 4'hF;
        step();
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        rsp_ready = 4'd0;
    endtask

    typedef struct {
        logic [3:0]  mask;
        int          grant;
        logic [31:0] data;
        logic        flag;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, prev, k, bad, early;
        exp_a    = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40800000};
        req_op_a = OPS_A;
        req_op_b = OPS_B;
        // Results: r0 1.0+2.0=3.0, r1 2.0+2.0=4.0, r2 1.5+0.5=2.0, r3 4.0+1.0=5.0
        tbl[0] = '{4'b1111, 0, 32'h40400000, 1'b0};
        tbl[1] = '{4'b1110, 1, 32'h40800000, 1'b1};
        tbl[2] = '{4'b1100, 2, 32'h40000000, 1'b0};
        tbl[3] = '{4'b1000, 3, 32'h40A00000, 1'b1};
        tbl[4] = '{4'b0001, 0, 32'h40400000, 1'b0};
        tbl[5] = '{4'b1011, 1, 32'h40800000, 1'b1};
        tbl[6] = '{4'b1001, 3, 32'h40A00000, 1'b1};
        tbl[7] = '{4'b0101, 0, 32'h40400000, 1'b0};
        tbl[8] = '{4'b0101, 2, 32'h40000000, 1'b0};
        tbl[9] = '{4'b0011, 0, 32'h40400000, 1'b0};

        do_reset();

        // Single operation, exact cycle timing.
        req_valid = 4'b0001;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'd1);
        t = cyc_n;
        step();
        req_valid = 4'd0;
        chk("t1_start", 32'(fpu_start), 32'd1);
        chk("t1_state_issue", 32'(fsm_state), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_op_b", fpu_op_b, 32'h40000000);
        step();
        chk("t1_start_pulse", 32'(fpu_start), 32'd0);
        early = 0;
        for (int j = 0; j < L; j++) begin
            if (rsp_valid != 4'd0) early++;
            step();
        end
        chk("t1_no_early_rsp", 32'(early), 32'd0);
        chk("t1_rsp_cycle", 32'(cyc_n - t), 32'(L + 2));
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_data", rsp_data, 32'h40400000);
        chk("t1_rsp_status", 32'(rsp_status), 32'd1);
        rsp_ready = 4'b0001;
        step();
        chk("t1_back_idle", 32'(fsm_state), 32'd0);
        chk("t1_rsp_clear", 32'(rsp_valid), 32'd0);
        rsp_ready = 4'd0;

        // Arbitration order and throughput from reset.
        do_reset();
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].mask, tbl[i].grant, tbl[i].data, tbl[i].flag, t);
            if (i > 0) chk("throughput", 32'(t - prev), 32'(L + 3));
            prev = t;
        end

        // Back-pressure on requester 1 while others stay pending.
        req_valid = 4'b1111;
        #1;
        chk("t3_grant1", 32'(req_ready), 32'b0010);
        step();
        wait_rsp(k);
        chk("t3_latency", 32'(k), 32'(L + 1));
        rsp_ready = 4'b1101;
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            if (rsp_valid != 4'b0010 || rsp_data != 32'h40800000 || !busy ||
                req_ready != 4'd0 || fsm_state != 2'd3) bad++;
            step();
        end
        chk("t3_hold", 32'(bad), 32'd0);
        rsp_ready = 4'b0010;
        #1;
        chk("t3_still_valid", 32'(rsp_valid), 32'b0010);
        step();
        #1;
        chk("t3_idle", 32'(fsm_state), 32'd0);
        chk("t3_next_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'd0;
        rsp_ready = 4'd0;
        wait_rsp(k);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("t6_rsp_data", rsp_data, 32'h40000000);

        // Ready on the wrong ports must not release requester 2.
        rsp_ready = 4'b1011;
        bad = 0;
        for (int j = 0; j < 6; j++) begin
            if (rsp_valid != 4'b0100 || fsm_state != 2'd3) bad++;
            step();
        end
        chk("t6_wrong_port", 32'(bad), 32'd0);
        rsp_ready = 4'b0100;
        step();
        chk("t6_release", 32'(fsm_state), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        rsp_ready = 4'd0;

        // Reset while waiting with count 3.
        req_valid = 4'b1000;
        #1;
        chk("t4_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'd0;
        repeat (5) step();
        chk("t4_in_wait", 32'(fsm_state), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_state", 32'(fsm_state), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_op_a", fpu_op_a, 32'd0);
        chk("t4_rsp_data", rsp_data, 32'd0);
        bad = 0;
        for (int j = 0; j < 15; j++) begin
            if (rsp_valid != 4'd0 || fpu_start || busy) bad++;
            step();
        end
        chk("t4_no_rsp", 32'(bad), 32'd0);
        run_op(4'b1100, 2, 32'h40000000, 1'b0, t);

        // Operands changed after acceptance must not reach the fpu.
        req_valid = 4'b1000;
        #1;
        chk("t5_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'd0;
        req_op_a[127:96] = 32'h12345678;
        bad = 0;
        k = 0;
        while (rsp_valid == 4'd0 && k < 40) begin
            if (fpu_op_a != 32'h40800000 || fpu_op_b != 32'h3F800000) bad++;
            step();
            k++;
        end
        chk("t5_latency", 32'(k), 32'(L + 1));
        for (int j = 0; j < 3; j++) begin
            if (fpu_op_a != 32'h40800000) bad++;
            step();
        end
        chk("t5_rsp_data", rsp_data, 32'h40A00000);
        chk("t5_rsp_flag", 32'(rsp_flag), 32'd1);
        rsp_ready = 4'b1000;
        step();
        rsp_ready = 4'd0;
        chk("t5_idle", 32'(fsm_state), 32'd0);
        chk("t5_op_after", fpu_op_a, 32'h40800000);
        chk("t5_op_hold", 32'(bad), 32'd0);
        req_op_a = OPS_A;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
